// File: rtl/vga_pmod_out.sv
// VGA output stage for a 2-bit-per-channel PMOD: re-times the pattern generator's
// syncs, gates pixels to the active window and applies RGB111, dithered grayscale and scanlines.
module vga_pmod_out #(
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [2:0] rgb_in,
  input  logic       mode,
  input  logic       scanline,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       locked
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {WAIT, BACK, ACTIVE, FRONT} hstate_t;

  hstate_t       state, state_nx;
  logic [CW-1:0] hcnt, hcnt_nx;
  logic [CW-1:0] vline;
  logic          hs1, vs1;
  logic [2:0]    rgb1;
  logic          mode1, scan1;
  logic          hrise, hfall, vrise;

  // First pipeline stage doubles as the edge-detect history for the syncs.
  assign hrise = hsync_in & ~hs1;
  assign hfall = ~hsync_in & hs1;
  assign vrise = vsync_in & ~vs1;

  // Horizontal window state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      hcnt  <= '0;
    end else begin
      state <= state_nx;
      hcnt  <= hcnt_nx;
    end
  end

  // Horizontal window next state; sync edges override the porch counting.
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    case (state)
      BACK: begin
        hcnt_nx = hcnt + CW'(1);
        if (hcnt == CW'(H_BACK - 1)) begin
          state_nx = ACTIVE;
          hcnt_nx  = '0;
        end
      end
      ACTIVE: begin
        hcnt_nx = hcnt + CW'(1);
        if (hcnt == CW'(H_ACTIVE - 1)) state_nx = FRONT;
      end
      default: ;
    endcase
    if (hrise) begin
      state_nx = BACK;
      hcnt_nx  = '0;
    end
    if (hfall) state_nx = WAIT;
  end

  // Line counter, lock flag and input stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      vline  <= CMAX;
      locked <= 1'b0;
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      rgb1   <= '0;
      mode1  <= 1'b0;
      scan1  <= 1'b0;
    end else begin
      if (vrise) vline <= '0;
      else if (hfall && vline != CMAX) vline <= vline + CW'(1);
      if (vrise) locked <= 1'b1;
      hs1   <= hsync_in;
      vs1   <= vsync_in;
      rgb1  <= rgb_in;
      mode1 <= mode;
      scan1 <= scanline;
    end
  end

  logic [CW-1:0] aline;
  logic          v_act, pix_en;
  logic [1:0]    lvl, pr, pg, pb;

  // Pixel colour for the sample held in the input stage.
  always_comb begin
    aline  = vline - CW'(V_BACK);
    v_act  = (vline >= CW'(V_BACK)) && (vline < CW'(V_BACK + V_ACTIVE));
    pix_en = (state == ACTIVE) && v_act && locked;
    lvl    = rgb1[2:1];
    if (rgb1[0] && (hcnt[0] ^ aline[0]) && lvl != 2'd3) lvl = lvl + 2'd1;
    if (mode1) begin
      pr = lvl;
      pg = lvl;
      pb = lvl;
    end else begin
      pr = {2{rgb1[2]}};
      pg = {2{rgb1[1]}};
      pb = {2{rgb1[0]}};
    end
    if (scan1 && aline[0]) begin
      pr = pr >> 1;
      pg = pg >> 1;
      pb = pb >> 1;
    end
    if (!pix_en) begin
      pr = '0;
      pg = '0;
      pb = '0;
    end
  end

  // Output stage keeps syncs and colour mutually aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      hsync <= hs1;
      vsync <= vs1;
      r     <= pr;
      g     <= pg;
      b     <= pb;
    end
  end

endmodule
